// File: rtl/uart_msg_seq_pkg.sv
// Shared types and default constants for the UART message sequencer.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  localparam int DEF_MSG_DEPTH  = 32;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_SETTLE_CYC = 2;
  localparam int DEF_GAP_CYC    = 1000;

  // Counter widths cover the full legal parameter ranges (SETTLE 1..15, GAP < 2^20).
  localparam int SETTLE_W = 4;
  localparam int GAP_W    = 20;

endpackage

// File: rtl/uart_msg_seq_if.sv
// Control, buffer-write and UART signals of the message sequencer.
interface uart_msg_seq_if
  import uart_seq_pkg::*;
#(
  parameter int MSG_DEPTH = DEF_MSG_DEPTH,
  parameter int DATA_W    = DEF_DATA_W
);
  localparam int ADDR_W = $clog2(MSG_DEPTH);
  localparam int LEN_W  = $clog2(MSG_DEPTH + 1);

  logic              buf_wr_i;
  logic [ADDR_W-1:0] buf_addr_i;
  logic [DATA_W-1:0] buf_dat_i;
  logic [LEN_W-1:0]  len_i;
  logic              repeat_i;
  logic              start_i;
  logic              abort_i;
  logic              uart_busy_i;
  logic              uart_wr_o;
  logic [DATA_W-1:0] uart_dat_o;
  logic              busy_o;
  logic              done_o;
  logic              aborted_o;
  logic [ADDR_W-1:0] idx_o;

  modport master (
    output buf_wr_i, buf_addr_i, buf_dat_i, len_i, repeat_i, start_i, abort_i, uart_busy_i,
    input  uart_wr_o, uart_dat_o, busy_o, done_o, aborted_o, idx_o
  );

  modport slave (
    input  buf_wr_i, buf_addr_i, buf_dat_i, len_i, repeat_i, start_i, abort_i, uart_busy_i,
    output uart_wr_o, uart_dat_o, busy_o, done_o, aborted_o, idx_o
  );

endinterface

// File: rtl/uart_msg_seq_buf.sv
// Message buffer: synchronous write, asynchronous read (distributed RAM), never reset.
module msg_buf
  import uart_seq_pkg::*;
#(
  parameter int DEPTH  = DEF_MSG_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_dat_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_i) begin
      r_mem[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = r_mem[rd_addr_i];

endmodule

// File: rtl/uart_msg_seq.sv
// Sends a buffered message to a UART one character at a time, optionally repeating it.
module uart_msg_seq
  import uart_seq_pkg::*;
#(
  parameter int MSG_DEPTH  = DEF_MSG_DEPTH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC
) (
  input logic           clk,
  input logic           rst,
  uart_msg_seq_if.slave bus
);

  localparam int ADDR_W = $clog2(MSG_DEPTH);
  localparam int LEN_W  = $clog2(MSG_DEPTH + 1);
  localparam logic [LEN_W-1:0]    LEN_MAX     = LEN_W'(MSG_DEPTH);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(GAP_CYC - 1);

  state_t              r_state;
  logic [LEN_W-1:0]    r_len;
  logic                r_rep;
  logic [ADDR_W-1:0]   r_idx;
  logic [SETTLE_W-1:0] r_settle;
  logic [GAP_W-1:0]    r_gap;
  logic [DATA_W-1:0]   r_dat;
  logic                r_done;
  logic                r_aborted;

  logic [DATA_W-1:0]   w_rd_dat;
  logic                w_last;

  msg_buf #(
    .DEPTH  (MSG_DEPTH),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .wr_i      (bus.buf_wr_i),
    .wr_addr_i (bus.buf_addr_i),
    .wr_dat_i  (bus.buf_dat_i),
    .rd_addr_i (r_idx),
    .rd_dat_o  (w_rd_dat)
  );

  assign w_last = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_rep     <= 1'b0;
      r_idx     <= '0;
      r_settle  <= '0;
      r_gap     <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (r_state != ST_IDLE && bus.abort_i) begin
        r_state   <= ST_IDLE;
        r_idx     <= '0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start_i) begin
              r_len <= (bus.len_i > LEN_MAX) ? LEN_MAX : bus.len_i;
              r_rep <= bus.repeat_i;
              r_idx <= '0;
              if (bus.len_i == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= ST_ISSUE;
              end
            end
          end
          ST_ISSUE: begin
            r_settle <= '0;
            r_state  <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (r_settle == SETTLE_LAST) begin
              r_state <= ST_WAIT;
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end
          ST_WAIT: begin
            if (!bus.uart_busy_i) begin
              if (!w_last) begin
                r_idx   <= r_idx + 1'b1;
                r_state <= ST_ISSUE;
              end else if (r_rep) begin
                if (GAP_CYC == 0) begin
                  r_idx   <= '0;
                  r_state <= ST_ISSUE;
                end else begin
                  r_gap   <= '0;
                  r_state <= ST_GAP;
                end
              end else begin
                r_idx   <= '0;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end
          ST_GAP: begin
            if (r_gap == GAP_LAST) begin
              r_idx   <= '0;
              r_state <= ST_ISSUE;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // The character is captured during ISSUE (even if aborted) so it stays on the bus afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dat <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_dat <= w_rd_dat;
    end
  end

  // During ISSUE the live read is shown so a same-cycle write cannot alter the sent byte.
  assign bus.uart_wr_o  = (r_state == ST_ISSUE);
  assign bus.uart_dat_o = (r_state == ST_ISSUE) ? w_rd_dat : r_dat;
  assign bus.busy_o     = (r_state != ST_IDLE);
  assign bus.done_o     = r_done;
  assign bus.aborted_o  = r_aborted;
  assign bus.idx_o      = r_idx;

endmodule

// File: tb/tb_uart_msg_seq.sv
// Scoreboard bench for uart_msg_seq with a UART model that stays busy 10 cycles per byte.
module tb_uart_msg_seq;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   wr_count = 0;
  int   done_count = 0;
  int   abort_count = 0;
  int   idx_back = 0;
  int   idx_max = 0;
  int   prev_idx = 0;
  bit   prev_busy = 0;
  int   busy_cnt = 0;
  logic [7:0] exp_q[$];
  int   wr_times[$];

  uart_msg_seq_if #(.MSG_DEPTH(32), .DATA_W(8)) bus ();

  uart_msg_seq #(
    .MSG_DEPTH  (32),
    .DATA_W     (8),
    .SETTLE_CYC (2),
    .GAP_CYC    (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.uart_wr_o) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.uart_busy_i = (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.uart_wr_o) begin
        wr_count++;
        wr_times.push_back(cyc);
        $display("t=%0d uart write idx=%0d dat=0x%02h", cyc, bus.idx_o, bus.uart_dat_o);
        if (exp_q.size() == 0) check("unexpected_wr", 32'(bus.uart_dat_o), 32'hFFFF_FFFF);
        else check("uart_dat", 32'(bus.uart_dat_o), 32'(exp_q.pop_front()));
      end
      if (bus.done_o) done_count++;
      if (bus.aborted_o) abort_count++;
      if (bus.busy_o && prev_busy && int'(bus.idx_o) < prev_idx) idx_back++;
      if (int'(bus.idx_o) > idx_max) idx_max = int'(bus.idx_o);
      prev_idx  = int'(bus.idx_o);
      prev_busy = bus.busy_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wr_buf(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.buf_wr_i   = 1'b1;
    bus.buf_addr_i = a;
    bus.buf_dat_i  = d;
    @(negedge clk);
    bus.buf_wr_i   = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] len, input logic rep);
    @(negedge clk);
    bus.len_i    = len;
    bus.repeat_i = rep;
    bus.start_i  = 1'b1;
    @(negedge clk);
    bus.start_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_wr(input int n, input int budget);
    int k = 0;
    while (wr_count < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_wr", wr_count, n);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_count < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_done", done_count, n);
  endtask

  task automatic check_zero_outputs(input string phase);
    check({phase, "_wr"},      32'(bus.uart_wr_o), 0);
    check({phase, "_dat"},     32'(bus.uart_dat_o), 0);
    check({phase, "_busy"},    32'(bus.busy_o), 0);
    check({phase, "_done"},    32'(bus.done_o), 0);
    check({phase, "_aborted"}, 32'(bus.aborted_o), 0);
    check({phase, "_idx"},     32'(bus.idx_o), 0);
  endtask

  initial begin
    int base;
    int d0;
    int a0;
    rst            = 1'b1;
    bus.buf_wr_i   = 1'b0;
    bus.buf_addr_i = '0;
    bus.buf_dat_i  = '0;
    bus.len_i      = '0;
    bus.repeat_i   = 1'b0;
    bus.start_i    = 1'b0;
    bus.abort_i    = 1'b0;
    idle(3);
    check_zero_outputs("reset");
    rst = 1'b0;

    // One-shot "AB"
    wr_buf(5'd0, 8'h41);
    wr_buf(5'd1, 8'h42);
    base = wr_count;
    d0   = done_count;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    do_start(6'd2, 1'b0);
    #1;
    check("start_latency_wr", 32'(bus.uart_wr_o), 1);
    wait_done(d0 + 1, 200);
    check("ab_busy_after_done", 32'(bus.busy_o), 0);
    idle(20);
    check("ab_wr_count", wr_count - base, 2);
    check("ab_done_count", done_count - d0, 1);

    // Zero-length start
    base = wr_count;
    do_start(6'd0, 1'b0);
    #1;
    check("len0_done", 32'(bus.done_o), 1);
    check("len0_wr", 32'(bus.uart_wr_o), 0);
    check("len0_busy", 32'(bus.busy_o), 0);
    idle(10);
    check("len0_wr_count", wr_count - base, 0);

    // Over-length request is clamped to the buffer depth
    for (int i = 0; i < 32; i++) begin
      wr_buf(5'(i), 8'(i ^ 8'h5A));
      exp_q.push_back(8'(i ^ 8'h5A));
    end
    base     = wr_count;
    d0       = done_count;
    idx_back = 0;
    idx_max  = 0;
    do_start(6'd40, 1'b0);
    wait_done(d0 + 1, 1000);
    check("len40_idx_after_done", 32'(bus.idx_o), 0);
    idle(20);
    check("len40_wr_count", wr_count - base, 32);
    check("len40_idx_max", idx_max, 31);
    check("len40_idx_no_wrap", idx_back, 0);

    // Repeat mode with gap, aborted during the second pass
    wr_buf(5'd0, 8'h10);
    wr_buf(5'd1, 8'h11);
    wr_buf(5'd2, 8'h12);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i % 3));
    wr_times.delete();
    base = wr_count;
    d0   = done_count;
    a0   = abort_count;
    do_start(6'd3, 1'b1);
    wait_wr(base + 5, 300);
    check("char_period", wr_times[1] - wr_times[0], 12);
    check("gap_period", wr_times[3] - wr_times[2], 17);
    @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    #1;
    check("abort_pulse", 32'(bus.aborted_o), 1);
    check("abort_busy", 32'(bus.busy_o), 0);
    check("abort_wr", 32'(bus.uart_wr_o), 0);
    idle(60);
    check("abort_no_more_wr", wr_count - base, 5);
    check("abort_no_done", done_count - d0, 0);
    check("abort_count", abort_count - a0, 1);

    // Start ignored in WAIT, then reset during SETTLE
    wr_buf(5'd0, 8'h41);
    wr_buf(5'd1, 8'h42);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    base = wr_count;
    d0   = done_count;
    a0   = abort_count;
    do_start(6'd2, 1'b0);
    idle(5);
    do_start(6'd1, 1'b0);
    wait_wr(base + 2, 100);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    check_zero_outputs("midrst");
    idle(1);
    rst = 1'b0;
    idle(20);
    check("midrst_no_done", done_count - d0, 0);
    check("midrst_no_abort", abort_count - a0, 0);
    check("midrst_wr_count", wr_count - base, 2);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    do_start(6'd2, 1'b0);
    wait_done(d0 + 1, 200);
    check("fresh_wr_count", wr_count - base, 4);

    // Write to the address being issued in the ISSUE cycle
    wr_buf(5'd0, 8'h61);
    wr_buf(5'd1, 8'h62);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    exp_q.push_back(8'h71);
    exp_q.push_back(8'h62);
    base = wr_count;
    @(negedge clk);
    bus.len_i    = 6'd2;
    bus.repeat_i = 1'b1;
    bus.start_i  = 1'b1;
    @(negedge clk);
    bus.start_i    = 1'b0;
    bus.buf_wr_i   = 1'b1;
    bus.buf_addr_i = 5'd0;
    bus.buf_dat_i  = 8'h71;
    @(negedge clk);
    bus.buf_wr_i   = 1'b0;
    wait_wr(base + 4, 200);
    @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    #1;
    check("same_addr_abort", 32'(bus.aborted_o), 1);
    idle(40);
    check("same_addr_wr_count", wr_count - base, 4);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
